// File: rtl/i2s_tx_master.sv
// I2S master transmitter: derives SCK/LRCLK from m_clk and serialises stereo pairs MSB first.
// Define I2S_TX_LJ_EN for left-justified framing (no one-SCK delay bit); default is standard I2S.
`default_nettype none

module i2s_tx_master #(
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32,
  parameter int SCK_DIV = 16
) (
  input  logic              m_clk,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_left,
  input  logic [DATA_W-1:0] tx_right,
  output logic              i2s_sck,
  output logic              i2s_lrclk,
  output logic              i2s_sdout,
  output logic              frame_start,
  output logic              underrun
);

  localparam int DW = $clog2(SCK_DIV);
  localparam int BW = $clog2(2 * SLOT_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(SCK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_W);
  localparam logic [BW-1:0] DATA_LEN = BW'(DATA_W);

  logic [DW-1:0]     div_cnt;
  logic [DW-1:0]     div_nxt;
  logic [BW-1:0]     bit_cnt;
  logic [BW-1:0]     bit_nxt;
  logic [BW-1:0]     slot;
  logic              in_right;
  logic              is_boundary;
  logic              is_frame_start;
  logic              emit;
  logic              accept;

  logic              buf_full;
  logic [DATA_W-1:0] buf_left;
  logic [DATA_W-1:0] buf_right;
  logic [DATA_W-1:0] sh_left;
  logic [DATA_W-1:0] sh_right;
  logic [DATA_W-1:0] sh_left_nxt;
  logic [DATA_W-1:0] sh_right_nxt;
  logic [DATA_W-1:0] load_left;
  logic [DATA_W-1:0] load_right;
  logic              sdout_nxt;

  assign tx_ready       = !buf_full;
  assign accept         = tx_valid && !buf_full;
  assign is_boundary    = (div_cnt == '0);
  assign is_frame_start = tx_en && is_boundary && (bit_cnt == '0);
  assign in_right       = (bit_cnt >= SLOT_LEN);
  assign slot           = in_right ? (bit_cnt - SLOT_LEN) : bit_cnt;

  // Slots that carry a sample bit; standard I2S leaves slot 0 as the delay bit.
`ifdef I2S_TX_LJ_EN
  assign emit = (slot < DATA_LEN);
`else
  assign emit = (slot != '0) && (slot <= DATA_LEN);
`endif

  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    bit_nxt = bit_cnt;
    if (div_cnt == DIV_LAST) begin
      bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

  // An empty buffer at frame start sends an all-zero frame.
  always_comb begin
    load_left    = buf_full ? buf_left  : '0;
    load_right   = buf_full ? buf_right : '0;
    sh_left_nxt  = sh_left;
    sh_right_nxt = sh_right;
    sdout_nxt    = i2s_sdout;
    if (is_frame_start) begin
`ifdef I2S_TX_LJ_EN
      sdout_nxt   = load_left[DATA_W-1];
      sh_left_nxt = load_left << 1;
`else
      sdout_nxt   = 1'b0;
      sh_left_nxt = load_left;
`endif
      sh_right_nxt = load_right;
    end else if (is_boundary) begin
      sdout_nxt = 1'b0;
      if (emit && in_right) begin
        sdout_nxt    = sh_right[DATA_W-1];
        sh_right_nxt = sh_right << 1;
      end else if (emit) begin
        sdout_nxt   = sh_left[DATA_W-1];
        sh_left_nxt = sh_left << 1;
      end
    end
  end

  // Outputs follow the counter tick just processed, so sdout and the SCK fall move together.
  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      sh_left     <= '0;
      sh_right    <= '0;
      i2s_sck     <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_sdout   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else if (tx_en) begin
      div_cnt     <= div_nxt;
      bit_cnt     <= bit_nxt;
      sh_left     <= sh_left_nxt;
      sh_right    <= sh_right_nxt;
      i2s_sck     <= (div_cnt >= DIV_HALF);
      i2s_lrclk   <= in_right;
      i2s_sdout   <= sdout_nxt;
      frame_start <= is_frame_start;
      underrun    <= is_frame_start && !buf_full;
    end else begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      sh_left     <= '0;
      sh_right    <= '0;
      i2s_sck     <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_sdout   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end
  end

  // The holding buffer survives tx_en=0 so a pending pair goes out after re-enable.
  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full  <= 1'b0;
      buf_left  <= '0;
      buf_right <= '0;
    end else if (accept) begin
      buf_full  <= 1'b1;
      buf_left  <= tx_left;
      buf_right <= tx_right;
    end else if (is_frame_start) begin
      buf_full  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx_master.sv
// Self-checking bench for i2s_tx_master: a time-indexed frame model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_i2s_tx_master;

  localparam int DATA_W  = 24;
  localparam int SLOT_W  = 32;
  localparam int SCK_DIV = 16;
  localparam int FRAME   = 2 * SLOT_W * SCK_DIV;
`ifdef I2S_TX_LJ_EN
  localparam int OFS = 0;
`else
  localparam int OFS = 1;
`endif

  logic              m_clk = 1'b0;
  logic              rst_n;
  logic              tx_en;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_left;
  logic [DATA_W-1:0] tx_right;
  logic              i2s_sck;
  logic              i2s_lrclk;
  logic              i2s_sdout;
  logic              frame_start;
  logic              underrun;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 0;
  bit cnt_en = 0;
  int c_ur = 0;
  int c_fs = 0;
  int c_one = 0;

  int                m_t = 0;
  bit                m_full = 0;
  bit                m_acc = 0;
  bit                m_take = 0;
  logic [DATA_W-1:0] m_buf_l = '0;
  logic [DATA_W-1:0] m_buf_r = '0;
  logic [DATA_W-1:0] m_cur_l = '0;
  logic [DATA_W-1:0] m_cur_r = '0;
  logic [DATA_W-1:0] m_word = '0;
  int                m_div = 0;
  int                m_bit = 0;
  int                m_s = 0;
  bit                e_sck = 0;
  bit                e_lr = 0;
  bit                e_sd = 0;
  bit                e_fs = 0;
  bit                e_ur = 0;

  i2s_tx_master #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .SCK_DIV(SCK_DIV)) dut (
    .m_clk(m_clk), .rst_n(rst_n), .tx_en(tx_en), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_left(tx_left), .tx_right(tx_right), .i2s_sck(i2s_sck), .i2s_lrclk(i2s_lrclk),
    .i2s_sdout(i2s_sdout), .frame_start(frame_start), .underrun(underrun)
  );

  always #5 m_clk = ~m_clk;

  // Model: enabled tick t fixes position in the frame; frame boundaries pull from a 1-deep buffer.
  always @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_full = 0; m_acc = 0; m_buf_l = '0; m_buf_r = '0; m_cur_l = '0; m_cur_r = '0;
      e_sck = 0; e_lr = 0; e_sd = 0; e_fs = 0; e_ur = 0;
    end else begin
      m_take = tx_valid && !m_full;
      m_acc  = m_take;
      if (tx_en) begin
        m_div = m_t % SCK_DIV;
        m_bit = m_t / SCK_DIV;
        e_fs  = (m_t == 0);
        e_ur  = 0;
        if (e_fs) begin
          m_cur_l = m_full ? m_buf_l : '0;
          m_cur_r = m_full ? m_buf_r : '0;
          e_ur    = !m_full;
          m_full  = 0;
        end
        e_sck  = (m_div >= SCK_DIV / 2);
        e_lr   = (m_bit >= SLOT_W);
        m_s    = m_bit % SLOT_W;
        m_word = e_lr ? m_cur_r : m_cur_l;
        if (m_s >= OFS && m_s < OFS + DATA_W) e_sd = m_word[DATA_W - 1 - (m_s - OFS)];
        else e_sd = 0;
        m_t = (m_t + 1) % FRAME;
      end else begin
        m_t = 0; m_cur_l = '0; m_cur_r = '0;
        e_sck = 0; e_lr = 0; e_sd = 0; e_fs = 0; e_ur = 0;
      end
      if (m_take) begin
        m_full = 1; m_buf_l = tx_left; m_buf_r = tx_right;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge m_clk) begin
    if (cmp_en) begin
      checkOutput("sck", 32'(i2s_sck), 32'(e_sck));
      checkOutput("lrclk", 32'(i2s_lrclk), 32'(e_lr));
      checkOutput("sdout", 32'(i2s_sdout), 32'(e_sd));
      checkOutput("frame_start", 32'(frame_start), 32'(e_fs));
      checkOutput("underrun", 32'(underrun), 32'(e_ur));
      checkOutput("tx_ready", 32'(tx_ready), 32'(!m_full));
    end
  end

  always @(negedge m_clk) begin
    if (cnt_en) begin
      c_ur  += int'(underrun);
      c_fs  += int'(frame_start);
      c_one += int'(i2s_sdout);
    end
  end

  task automatic applyStimulus(input bit valid, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    tx_valid = valid;
    tx_left  = l;
    tx_right = r;
  endtask

  task automatic doReset();
    @(negedge m_clk);
    #2;
    rst_n = 0;
    tx_en = 0;
    applyStimulus(1'b0, '0, '0);
    repeat (2) @(negedge m_clk);
    #2 rst_n = 1;
    @(negedge m_clk);
  endtask

  task automatic pushPair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input bit hold);
    bit got = 0;
    applyStimulus(1'b1, l, r);
    for (int i = 0; i < 4 * FRAME && !got; i++) begin
      @(posedge m_clk);
      #1 got = m_acc;
    end
    checkOutput("push_accept", 32'(got), 32'd1);
    @(negedge m_clk);
    if (!hold) applyStimulus(1'b0, '0, '0);
  endtask

  task automatic startCount();
    #1;
    c_ur = 0; c_fs = 0; c_one = 0;
    cnt_en = 1;
  endtask

  // Sends one pair from a cold start and decodes the serial stream sampled on SCK rises.
  task automatic runPatternFrame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    bit                bits[2][SLOT_W];
    int                rises = 0;
    int                left_rises = 0;
    int                lr_rise[$];
    bit                p_sck = 0;
    bit                p_lr = 0;
    logic [DATA_W-1:0] wl = '0;
    logic [DATA_W-1:0] wr = '0;
    int                pad = 0;
    doReset();
    pushPair(l, r, 1'b0);
    tx_en = 1;
    for (int k = 0; k < 2 * FRAME + 8; k++) begin
      @(negedge m_clk);
      if (k == 0) begin
        checkOutput("first_frame_start", 32'(frame_start), 32'd1);
        checkOutput("first_underrun", 32'(underrun), 32'd0);
      end
      if (i2s_sck && !p_sck && k < FRAME && rises < 2 * SLOT_W) begin
        bits[rises / SLOT_W][rises % SLOT_W] = i2s_sdout;
        if (!i2s_lrclk) left_rises++;
        rises++;
      end
      if (i2s_lrclk && !p_lr) lr_rise.push_back(k);
      p_sck = i2s_sck;
      p_lr  = i2s_lrclk;
    end
    checkOutput("lrclk_period", (lr_rise.size() >= 2) ? 32'(lr_rise[1] - lr_rise[0]) : 32'd0, 32'(FRAME));
    checkOutput("sck_per_slot", 32'(left_rises), 32'(SLOT_W));
    for (int s = 0; s < SLOT_W; s++) begin
      if (s >= OFS && s < OFS + DATA_W) begin
        wl[DATA_W - 1 - (s - OFS)] = bits[0][s];
        wr[DATA_W - 1 - (s - OFS)] = bits[1][s];
      end else begin
        pad += int'(bits[0][s]) + int'(bits[1][s]);
      end
    end
    checkOutput("left_word", 32'(wl), 32'(l));
    checkOutput("right_word", 32'(wr), 32'(r));
    checkOutput("pad_bits", 32'(pad), 32'd0);
    tx_en = 0;
  endtask

  initial begin
    bit v;
    rst_n = 0;
    tx_en = 0;
    applyStimulus(1'b0, '0, '0);
    @(negedge m_clk);
    checkOutput("rst_sck", 32'(i2s_sck), 32'd0);
    checkOutput("rst_lrclk", 32'(i2s_lrclk), 32'd0);
    checkOutput("rst_sdout", 32'(i2s_sdout), 32'd0);
    checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
    checkOutput("rst_frame_start", 32'(frame_start), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    #2 rst_n = 1;
    @(negedge m_clk);
    cmp_en = 1;

    $display("[TB] pattern frame");
    runPatternFrame(24'hA5A5A5, 24'h5A5A5A);
`ifdef I2S_TX_LJ_EN
    runPatternFrame(24'h800001, 24'h000000);
`endif

    $display("[TB] back-to-back pairs");
    doReset();
    pushPair(24'h123456, 24'h654321, 1'b1);
    tx_en = 1;
    fork
      begin
        pushPair(24'hFFFFFF, 24'h000001, 1'b1);
        pushPair(24'h800000, 24'h7FFFFF, 1'b1);
        pushPair(24'h0F0F0F, 24'hF0F0F0, 1'b0);
      end
      begin
        startCount();
        repeat (4 * FRAME) @(negedge m_clk);
        #1 cnt_en = 0;
      end
    join
    checkOutput("b2b_underruns", 32'(c_ur), 32'd0);
    checkOutput("b2b_frames", 32'(c_fs), 32'd4);

    $display("[TB] idle link");
    doReset();
    tx_en = 1;
    startCount();
    repeat (3 * FRAME) @(negedge m_clk);
    #1 cnt_en = 0;
    checkOutput("idle_underruns", 32'(c_ur), 32'd3);
    checkOutput("idle_frames", 32'(c_fs), 32'd3);
    checkOutput("idle_sdout_ones", 32'(c_one), 32'd0);

    $display("[TB] disable mid-frame");
    doReset();
    pushPair(24'hC3C3C3, 24'hFFFFFF, 1'b0);
    tx_en = 1;
    pushPair(24'h3C3C3C, 24'h111111, 1'b0);
    for (int i = 0; i < 2 * FRAME && m_t != 641; i++) @(negedge m_clk);
    checkOutput("pre_disable_lrclk", 32'(i2s_lrclk), 32'd1);
    tx_en = 0;
    @(negedge m_clk);
    checkOutput("dis_sck", 32'(i2s_sck), 32'd0);
    checkOutput("dis_lrclk", 32'(i2s_lrclk), 32'd0);
    checkOutput("dis_sdout", 32'(i2s_sdout), 32'd0);
    checkOutput("dis_tx_ready", 32'(tx_ready), 32'd0);
    tx_en = 1;
    startCount();
    repeat (FRAME) @(negedge m_clk);
    #1 cnt_en = 0;
    checkOutput("reen_underruns", 32'(c_ur), 32'd0);
    checkOutput("reen_frames", 32'(c_fs), 32'd1);
    checkOutput("reen_tx_ready", 32'(tx_ready), 32'd1);

    $display("[TB] async reset mid-frame");
    doReset();
    pushPair(24'h0000FF, 24'hFF0000, 1'b0);
    tx_en = 1;
    repeat (200) @(negedge m_clk);
    pushPair(24'hABCDEF, 24'hFEDCBA, 1'b0);
    repeat (100) @(negedge m_clk);
    checkOutput("pre_reset_tx_ready", 32'(tx_ready), 32'd0);
    @(posedge m_clk);
    #2 rst_n = 0;
    #1;
    checkOutput("arst_sck", 32'(i2s_sck), 32'd0);
    checkOutput("arst_lrclk", 32'(i2s_lrclk), 32'd0);
    checkOutput("arst_sdout", 32'(i2s_sdout), 32'd0);
    checkOutput("arst_frame_start", 32'(frame_start), 32'd0);
    checkOutput("arst_underrun", 32'(underrun), 32'd0);
    checkOutput("arst_tx_ready", 32'(tx_ready), 32'd1);
    @(negedge m_clk);
    #2 rst_n = 1;
    @(negedge m_clk);
    checkOutput("post_reset_frame_start", 32'(frame_start), 32'd1);
    checkOutput("post_reset_underrun", 32'(underrun), 32'd1);
    tx_en = 0;

    $display("[TB] randomized traffic");
    doReset();
    for (int c = 0; c < 24000; c++) begin
      @(negedge m_clk);
      if (tx_en) begin
        if ($urandom_range(0, 2499) == 0) tx_en = 0;
      end else if ($urandom_range(0, 19) == 0) begin
        tx_en = 1;
      end
      if ((c / 4096) % 2 == 0) v = ($urandom_range(0, 3) == 0);
      else v = ($urandom_range(0, 1499) == 0);
      applyStimulus(v, DATA_W'($urandom()), DATA_W'($urandom()));
    end
    applyStimulus(1'b0, '0, '0);
    @(negedge m_clk);
    cmp_en = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
